// File: rtl/mandel_pkg.sv
// Shared constants, state encoding and colour mapping for the Mandelbrot frame engine.
package mandel_pkg;

  localparam int unsigned WIDTH_D = 27;
  localparam int unsigned FRAC_D  = 23;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    WRITE,
    DONE
  } state_e;

  // 4.0 expressed at the squared-product scale (2*frac fractional bits)
  function automatic logic [127:0] escape_limit(input int unsigned frac);
    return 128'(4) << (2 * frac);
  endfunction

  // Escaped pixels take the low byte of the count; 0 is remapped so it never reads as in-set
  function automatic logic [7:0] pixel_colour(input logic escaped, input logic [7:0] n_lsb);
    if (!escaped) return 8'h00;
    return (n_lsb == 8'h00) ? 8'hFF : n_lsb;
  endfunction

endpackage

// File: rtl/mandel_frame_engine_if.sv
// Host-parameter and pixel-buffer bus of the Mandelbrot frame engine.
interface mandel_frame_engine_if
  import mandel_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_D,
  parameter int unsigned ADDR_W = 19
);
  logic                     start;
  logic signed [WIDTH-1:0]  x_start;
  logic signed [WIDTH-1:0]  y_start;
  logic signed [WIDTH-1:0]  dx;
  logic signed [WIDTH-1:0]  dy;
  logic        [WIDTH-1:0]  max_iter;
  logic        [ADDR_W-1:0] vga_address;
  logic        [7:0]        vga_writedata;
  logic                     vga_write;
  logic                     vga_chipselect;
  logic                     vga_clken;
  logic                     done;
  logic        [31:0]       cycle_count;

  modport master (
    output start, x_start, y_start, dx, dy, max_iter,
    input  vga_address, vga_writedata, vga_write, vga_chipselect, vga_clken, done, cycle_count
  );

  modport slave (
    input  start, x_start, y_start, dx, dy, max_iter,
    output vga_address, vga_writedata, vga_write, vga_chipselect, vga_clken, done, cycle_count
  );
endinterface

// File: rtl/mandel_iter_step.sv
// Combinational z^2 + c step with the |z|^2 > 4 escape test on the untruncated sum.
module mandel_iter_step
  import mandel_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_D,
  parameter int unsigned FRAC  = FRAC_D
) (
  input  logic signed [WIDTH-1:0] zr,
  input  logic signed [WIDTH-1:0] zi,
  input  logic signed [WIDTH-1:0] cr,
  input  logic signed [WIDTH-1:0] ci,
  output logic signed [WIDTH-1:0] zr_next_c,
  output logic signed [WIDTH-1:0] zi_next_c,
  output logic                    escaped_c
);
  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [PW:0] ESC = (PW + 1)'(escape_limit(FRAC));

  logic signed [PW-1:0] zr_sq;
  logic signed [PW-1:0] zi_sq;
  logic signed [PW-1:0] zr_zi;
  logic signed [PW-1:0] re_diff;
  logic        [PW:0]   mag;

  assign zr_sq   = PW'(zr) * PW'(zr);
  assign zi_sq   = PW'(zi) * PW'(zi);
  assign zr_zi   = PW'(zr) * PW'(zi);
  assign re_diff = zr_sq - zi_sq;

  // Both squares are non-negative, so the extra bit keeps the sum exact
  assign mag       = (PW + 1)'(zr_sq) + (PW + 1)'(zi_sq);
  assign escaped_c = mag > ESC;

  // 2*zr*zi folded into a one-bit-smaller shift
  assign zr_next_c = WIDTH'(re_diff >>> FRAC) + cr;
  assign zi_next_c = WIDTH'(zr_zi >>> (FRAC - 1)) + ci;

endmodule

// File: rtl/mandel_frame_engine.sv
// Raster-order escape-time frame generator writing one colour byte per pixel into the VGA buffer.
module mandel_frame_engine
  import mandel_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_D,
  parameter int unsigned FRAC   = FRAC_D,
  parameter int unsigned H_RES  = 640,
  parameter int unsigned V_RES  = 480,
  parameter int unsigned ADDR_W = 19
) (
  input  logic                  clk,
  input  logic                  reset,
  mandel_frame_engine_if.slave  bus
);
  localparam int unsigned COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;

  state_e                  state;
  logic [COL_W-1:0]        col;
  logic [ROW_W-1:0]        row;
  logic [ADDR_W-1:0]       addr;
  logic signed [WIDTH-1:0] cr;
  logic signed [WIDTH-1:0] ci;
  logic signed [WIDTH-1:0] zr;
  logic signed [WIDTH-1:0] zi;
  logic signed [WIDTH-1:0] x_start_q;
  logic signed [WIDTH-1:0] dx_q;
  logic signed [WIDTH-1:0] dy_q;
  logic [WIDTH-1:0]        max_q;
  logic [WIDTH-1:0]        n;

  logic signed [WIDTH-1:0] zr_next;
  logic signed [WIDTH-1:0] zi_next;
  logic                    escaped;
  logic                    col_last;
  logic                    row_last;

  mandel_iter_step #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_step (
    .zr        (zr),
    .zi        (zi),
    .cr        (cr),
    .ci        (ci),
    .zr_next_c (zr_next),
    .zi_next_c (zi_next),
    .escaped_c (escaped)
  );

  assign col_last           = (col == COL_W'(H_RES - 1));
  assign row_last           = (row == ROW_W'(V_RES - 1));
  assign bus.vga_clken      = 1'b1;
  assign bus.vga_chipselect = bus.vga_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      col               <= '0;
      row               <= '0;
      addr              <= '0;
      cr                <= '0;
      ci                <= '0;
      zr                <= '0;
      zi                <= '0;
      x_start_q         <= '0;
      dx_q              <= '0;
      dy_q              <= '0;
      max_q             <= '0;
      n                 <= '0;
      bus.vga_address   <= '0;
      bus.vga_writedata <= '0;
      bus.vga_write     <= 1'b0;
      bus.done          <= 1'b0;
      bus.cycle_count   <= '0;
    end else begin
      // Busy-cycle timer, saturating; a new start below overrides with a clear
      if ((state inside {LOAD, ITER, WRITE}) && (bus.cycle_count != '1))
        bus.cycle_count <= bus.cycle_count + 32'd1;

      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            x_start_q       <= bus.x_start;
            dx_q            <= bus.dx;
            dy_q            <= bus.dy;
            max_q           <= bus.max_iter;
            cr              <= bus.x_start;
            ci              <= bus.y_start;
            col             <= '0;
            row             <= '0;
            addr            <= '0;
            bus.cycle_count <= '0;
            bus.done        <= 1'b0;
            state           <= LOAD;
          end
        end

        LOAD: begin
          zr    <= '0;
          zi    <= '0;
          n     <= '0;
          state <= ITER;
        end

        ITER: begin
          if (escaped || (n == max_q)) begin
            bus.vga_write     <= 1'b1;
            bus.vga_address   <= addr;
            bus.vga_writedata <= pixel_colour(escaped, n[7:0]);
            state             <= WRITE;
          end else begin
            zr <= zr_next;
            zi <= zi_next;
            n  <= n + WIDTH'(1);
          end
        end

        WRITE: begin
          bus.vga_write <= 1'b0;
          addr          <= addr + ADDR_W'(1);
          if (col_last) begin
            col <= '0;
            cr  <= x_start_q;
            row <= row + ROW_W'(1);
            ci  <= ci + dy_q;
          end else begin
            col <= col + COL_W'(1);
            cr  <= cr + dx_q;
          end
          if (col_last && row_last) begin
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            state <= LOAD;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mandel_frame_engine.sv
// Scoreboard bench: a 2x1 engine for per-pixel behaviour and a 3x2 engine for raster order.
module tb_mandel_frame_engine;
  localparam int unsigned W = 27;

  localparam logic signed [W-1:0] ZERO      = 27'sd0;
  localparam logic signed [W-1:0] ONE       = 27'sd8388608;
  localparam logic signed [W-1:0] TWO_Q     = 27'sd18874368;
  localparam logic signed [W-1:0] NEG_TWO   = -27'sd16777216;
  localparam logic signed [W-1:0] NEG_TWO_Q = -27'sd18874368;
  localparam logic [W-1:0]        MI50      = 27'd50;

  typedef struct packed {
    logic [18:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;
  wr_t  qa[$];
  wr_t  qb[$];
  wr_t  ea;
  wr_t  eb;

  always #5 clk = ~clk;

  mandel_frame_engine_if #(.WIDTH(W), .ADDR_W(19)) ifa ();
  mandel_frame_engine_if #(.WIDTH(W), .ADDR_W(19)) ifb ();

  mandel_frame_engine #(.WIDTH(W), .FRAC(23), .H_RES(2), .V_RES(1), .ADDR_W(19)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  mandel_frame_engine #(.WIDTH(W), .FRAC(23), .H_RES(3), .V_RES(2), .ADDR_W(19)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  // Every observed write must match the oldest expected write for that engine
  always @(negedge clk) begin
    if (!reset && ifa.vga_write === 1'b1) begin
      tests_run++;
      if (qa.size() == 0) begin
        tests_failed++;
        $display("FAIL a_write: unexpected write addr=%0d data=%02h", ifa.vga_address, ifa.vga_writedata);
      end else begin
        ea = qa.pop_front();
        if ({ifa.vga_chipselect, ifa.vga_address, ifa.vga_writedata} !== {1'b1, ea.addr, ea.data}) begin
          tests_failed++;
          $display("FAIL a_write: got cs=%b addr=%0d data=%02h expected cs=1 addr=%0d data=%02h",
                   ifa.vga_chipselect, ifa.vga_address, ifa.vga_writedata, ea.addr, ea.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && ifb.vga_write === 1'b1) begin
      tests_run++;
      if (qb.size() == 0) begin
        tests_failed++;
        $display("FAIL b_write: unexpected write addr=%0d data=%02h", ifb.vga_address, ifb.vga_writedata);
      end else begin
        eb = qb.pop_front();
        if ({ifb.vga_chipselect, ifb.vga_address, ifb.vga_writedata} !== {1'b1, eb.addr, eb.data}) begin
          tests_failed++;
          $display("FAIL b_write: got cs=%b addr=%0d data=%02h expected cs=1 addr=%0d data=%02h",
                   ifb.vga_chipselect, ifb.vga_address, ifb.vga_writedata, eb.addr, eb.data);
        end
      end
    end
  end

  task automatic start_a(input logic signed [W-1:0] xs, input logic signed [W-1:0] ys,
                         input logic [W-1:0] mi);
    @(posedge clk); #1;
    ifa.x_start = xs; ifa.y_start = ys; ifa.dx = ZERO; ifa.dy = ZERO;
    ifa.max_iter = mi; ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
  endtask

  task automatic wait_done_a(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ifa.done === 1'b1) break;
    end
  endtask

  task automatic frame_a(input logic signed [W-1:0] xs, input logic signed [W-1:0] ys,
                         input logic [W-1:0] mi, input logic [7:0] colour);
    qa.push_back({19'd0, colour});
    qa.push_back({19'd1, colour});
    start_a(xs, ys, mi);
    wait_done_a(2000);
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if ({ifa.vga_address, ifa.vga_writedata, ifa.vga_write, ifa.vga_chipselect, ifa.vga_clken,
         ifa.done, ifa.cycle_count} !== {19'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0}) begin
      tests_failed++;
      $display("FAIL reset_a: got addr=%0d data=%02h wr=%b cs=%b clken=%b done=%b cnt=%0d expected 0/00/0/0/1/0/0",
               ifa.vga_address, ifa.vga_writedata, ifa.vga_write, ifa.vga_chipselect, ifa.vga_clken,
               ifa.done, ifa.cycle_count);
    end
    tests_run++;
    if ({ifb.vga_address, ifb.vga_writedata, ifb.vga_write, ifb.vga_chipselect, ifb.vga_clken,
         ifb.done, ifb.cycle_count} !== {19'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0}) begin
      tests_failed++;
      $display("FAIL reset_b: got addr=%0d data=%02h wr=%b cs=%b clken=%b done=%b cnt=%0d expected 0/00/0/0/1/0/0",
               ifb.vga_address, ifb.vga_writedata, ifb.vga_write, ifb.vga_chipselect, ifb.vga_clken,
               ifb.done, ifb.cycle_count);
    end
  endtask

  task automatic test_origin();
    logic [31:0] cnt;
    frame_a(ZERO, ZERO, MI50, 8'h00);
    tests_run++;
    if (ifa.done !== 1'b1) begin
      tests_failed++; $display("FAIL origin_done: got %b expected 1", ifa.done);
    end
    tests_run++;
    if (qa.size() != 0) begin
      tests_failed++; $display("FAIL origin_pending: got %0d pending writes expected 0", qa.size());
    end
    tests_run++;
    if (ifa.cycle_count !== 32'd106) begin
      tests_failed++; $display("FAIL origin_cycles: got %0d expected 106", ifa.cycle_count);
    end
    cnt = ifa.cycle_count;
    repeat (5) @(negedge clk);
    tests_run++;
    if ({ifa.done, ifa.cycle_count, ifa.vga_write} !== {1'b1, 32'd106, 1'b0}) begin
      tests_failed++;
      $display("FAIL done_hold: got done=%b cnt=%0d wr=%b expected done=1 cnt=106 wr=0 (was %0d)",
               ifa.done, ifa.cycle_count, ifa.vga_write, cnt);
    end
    qa.delete();
  endtask

  task automatic test_fast_escape();
    frame_a(TWO_Q, ZERO, MI50, 8'h01);
    tests_run++;
    if ({ifa.done, ifa.cycle_count} !== {1'b1, 32'd8}) begin
      tests_failed++; $display("FAIL fast_escape: got done=%b cnt=%0d expected done=1 cnt=8", ifa.done, ifa.cycle_count);
    end
    tests_run++;
    if (qa.size() != 0) begin
      tests_failed++; $display("FAIL fast_escape_pending: got %0d expected 0", qa.size());
    end
    qa.delete();
  endtask

  task automatic test_two_step();
    qa.push_back({19'd0, 8'h03});
    qa.push_back({19'd1, 8'h03});
    start_a(ONE, ZERO, MI50);
    tests_run++;
    if (ifa.done !== 1'b0) begin
      tests_failed++; $display("FAIL restart_done_clear: got %b expected 0", ifa.done);
    end
    wait_done_a(2000);
    tests_run++;
    if ({ifa.done, ifa.cycle_count} !== {1'b1, 32'd12}) begin
      tests_failed++; $display("FAIL two_step: got done=%b cnt=%0d expected done=1 cnt=12", ifa.done, ifa.cycle_count);
    end
    tests_run++;
    if (qa.size() != 0) begin
      tests_failed++; $display("FAIL two_step_pending: got %0d expected 0", qa.size());
    end
    qa.delete();
  endtask

  task automatic test_boundary();
    frame_a(NEG_TWO, ZERO, MI50, 8'h00);
    tests_run++;
    if ({ifa.done, ifa.cycle_count} !== {1'b1, 32'd106}) begin
      tests_failed++; $display("FAIL boundary: got done=%b cnt=%0d expected done=1 cnt=106", ifa.done, ifa.cycle_count);
    end
    tests_run++;
    if (qa.size() != 0) begin
      tests_failed++; $display("FAIL boundary_pending: got %0d expected 0", qa.size());
    end
    qa.delete();
  endtask

  task automatic test_max_iter_zero();
    frame_a(TWO_Q, ZERO, 27'd0, 8'h00);
    tests_run++;
    if ({ifa.done, ifa.cycle_count} !== {1'b1, 32'd6}) begin
      tests_failed++; $display("FAIL max_iter_zero: got done=%b cnt=%0d expected done=1 cnt=6", ifa.done, ifa.cycle_count);
    end
    tests_run++;
    if (qa.size() != 0) begin
      tests_failed++; $display("FAIL max_iter_zero_pending: got %0d expected 0", qa.size());
    end
    qa.delete();
  endtask

  task automatic test_busy_start();
    qa.push_back({19'd0, 8'h03});
    qa.push_back({19'd1, 8'h03});
    start_a(ONE, ZERO, MI50);
    repeat (3) @(posedge clk);
    #1;
    ifa.x_start = ZERO; ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    wait_done_a(2000);
    tests_run++;
    if ({ifa.done, ifa.cycle_count} !== {1'b1, 32'd12}) begin
      tests_failed++; $display("FAIL busy_start: got done=%b cnt=%0d expected done=1 cnt=12", ifa.done, ifa.cycle_count);
    end
    tests_run++;
    if (qa.size() != 0) begin
      tests_failed++; $display("FAIL busy_start_pending: got %0d expected 0", qa.size());
    end
    qa.delete();
  endtask

  task automatic test_raster();
    logic [7:0] row_cols [3];
    row_cols[0] = 8'h01; row_cols[1] = 8'h00; row_cols[2] = 8'h01;
    for (int a = 0; a < 6; a++) qb.push_back({19'(a), row_cols[a % 3]});
    @(posedge clk); #1;
    ifb.x_start = TWO_Q; ifb.y_start = ZERO; ifb.dx = NEG_TWO_Q; ifb.dy = ZERO;
    ifb.max_iter = MI50; ifb.start = 1'b1;
    @(posedge clk); #1;
    ifb.start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (ifb.done === 1'b1) break;
    end
    tests_run++;
    if ({ifb.done, ifb.cycle_count} !== {1'b1, 32'd122}) begin
      tests_failed++; $display("FAIL raster: got done=%b cnt=%0d expected done=1 cnt=122", ifb.done, ifb.cycle_count);
    end
    tests_run++;
    if (qb.size() != 0) begin
      tests_failed++; $display("FAIL raster_pending: got %0d expected 0", qb.size());
    end
    qb.delete();
  endtask

  task automatic test_reset_mid_frame();
    qa.push_back({19'd0, 8'h00});
    start_a(ZERO, ZERO, MI50);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (qa.size() == 0) break;
    end
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({ifa.vga_write, ifa.done, ifa.cycle_count} !== {1'b0, 1'b0, 32'd0}) begin
      tests_failed++;
      $display("FAIL abort: got wr=%b done=%b cnt=%0d expected 0/0/0", ifa.vga_write, ifa.done, ifa.cycle_count);
    end
    repeat (150) @(negedge clk);
    tests_run++;
    if ({ifa.done, ifa.cycle_count} !== {1'b0, 32'd0}) begin
      tests_failed++;
      $display("FAIL abort_idle: got done=%b cnt=%0d expected 0/0", ifa.done, ifa.cycle_count);
    end
    frame_a(ZERO, ZERO, MI50, 8'h00);
    tests_run++;
    if ({ifa.done, ifa.cycle_count} !== {1'b1, 32'd106}) begin
      tests_failed++; $display("FAIL restart: got done=%b cnt=%0d expected done=1 cnt=106", ifa.done, ifa.cycle_count);
    end
    tests_run++;
    if (qa.size() != 0) begin
      tests_failed++; $display("FAIL restart_pending: got %0d expected 0", qa.size());
    end
    qa.delete();
  endtask

  initial begin
    ifa.start = 1'b0; ifa.x_start = ZERO; ifa.y_start = ZERO; ifa.dx = ZERO; ifa.dy = ZERO; ifa.max_iter = '0;
    ifb.start = 1'b0; ifb.x_start = ZERO; ifb.y_start = ZERO; ifb.dx = ZERO; ifb.dy = ZERO; ifb.max_iter = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_origin();
    test_fast_escape();
    test_two_step();
    test_boundary();
    test_max_iter_zero();
    test_busy_start();
    test_raster();
    test_reset_mid_frame();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
